// File: rtl/instr_fetch_unit_pkg.sv
// Types and constants shared by the fetch unit and the decode-side
// immediate generator.
package instr_fetch_unit_pkg;

    // Base RV32 major opcodes as seen in instr[6:0].
    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } op_type;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction fetches are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time
// and hands each fetched word to decode over a valid/ready handshake.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,

    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,

    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      op,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            misaligned_err
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic            r_misaligned_err;

    logic            w_rsp_take;
    logic            w_consume;

    // A response is kept only if nothing redirected fetch in the same cycle.
    assign w_rsp_take = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign w_consume  = (r_state == S_HOLD) && instr_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the next-state default is assigned first so no path through the
    // case leaves w_state_next unassigned (which would infer a latch).
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  w_state_next = S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    w_state_next = redirect_valid ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_next = redirect_valid ? S_REQ : S_HOLD;
                end else if (redirect_valid) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (redirect_valid || instr_ready) begin
                    w_state_next = S_REQ;
                end
            end
            S_DRAIN: begin
                // A response arriving alongside a redirect still retires the
                // orphan; otherwise the redirect only retargets the PC.
                if (imem_rsp_valid) begin
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc             <= RESET_PC;
            r_instr          <= '0;
            r_instr_pc       <= '0;
            r_misaligned_err <= 1'b0;
        end else begin
            r_misaligned_err <= redirect_valid && (redirect_target[1:0] != 2'b00);

            if (redirect_valid) begin
                r_pc <= align_pc(redirect_target);
            end else if (w_consume) begin
                r_pc <= r_pc + INSTR_BYTES;
            end

            if (w_rsp_take) begin
                r_instr    <= imem_rsp_data;
                r_instr_pc <= r_pc;
            end
        end
    end

    // Handshake outputs decode the state register only, never live inputs.
    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_pc;
    assign instr_valid    = (r_state == S_HOLD);
    assign instr          = r_instr;
    assign op             = r_instr[6:0];
    assign instr_pc       = r_instr_pc;
    assign misaligned_err = r_misaligned_err;

endmodule
